// File: rtl/ddr_slave_axi_arb2.sv
// ddr_slave_axi_arb2
// Two-master arbiter in front of the single DDR slave AXI-style port.
// Write (AW+W) and read (AR) address paths are arbitrated independently with
// round-robin priority; the winning master index is prepended to the ID so
// B and R responses are routed back by ID MSB with no tracking state.
// Ports:
//   clk, rst             : DDR slave clock, synchronous active-high reset
//   M0_*/M1_* WR_ADDR/WR_DATA/WR_BACK : master write channels
//   M0_*/M1_* RD_ADDR/RD_BACK         : master read channels
//   S_*                               : DDR slave port (ID one bit wider)
module ddr_slave_axi_arb2 #(
  parameter int MID_WIDTH  = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // master 0
  input  logic [MID_WIDTH-1:0]    M0_WR_ADDR_ID,
  input  logic [31:0]             M0_WR_ADDR,
  input  logic [7:0]              M0_WR_ADDR_LEN,
  input  logic [1:0]              M0_WR_ADDR_BURST,
  input  logic                    M0_WR_ADDR_VALID,
  output logic                    M0_WR_ADDR_READY,
  input  logic [DATA_WIDTH-1:0]   M0_WR_DATA,
  input  logic [DATA_WIDTH/8-1:0] M0_WR_DATA_STRB,
  input  logic                    M0_WR_DATA_LAST,
  input  logic                    M0_WR_DATA_VALID,
  output logic                    M0_WR_DATA_READY,
  output logic [MID_WIDTH-1:0]    M0_WR_BACK_ID,
  output logic [1:0]              M0_WR_BACK_RESP,
  output logic                    M0_WR_BACK_VALID,
  input  logic                    M0_WR_BACK_READY,
  input  logic [MID_WIDTH-1:0]    M0_RD_ADDR_ID,
  input  logic [31:0]             M0_RD_ADDR,
  input  logic [7:0]              M0_RD_ADDR_LEN,
  input  logic [1:0]              M0_RD_ADDR_BURST,
  input  logic                    M0_RD_ADDR_VALID,
  output logic                    M0_RD_ADDR_READY,
  output logic [MID_WIDTH-1:0]    M0_RD_BACK_ID,
  output logic [DATA_WIDTH-1:0]   M0_RD_DATA,
  output logic [1:0]              M0_RD_DATA_RESP,
  output logic                    M0_RD_DATA_LAST,
  output logic                    M0_RD_DATA_VALID,
  input  logic                    M0_RD_DATA_READY,
  // master 1
  input  logic [MID_WIDTH-1:0]    M1_WR_ADDR_ID,
  input  logic [31:0]             M1_WR_ADDR,
  input  logic [7:0]              M1_WR_ADDR_LEN,
  input  logic [1:0]              M1_WR_ADDR_BURST,
  input  logic                    M1_WR_ADDR_VALID,
  output logic                    M1_WR_ADDR_READY,
  input  logic [DATA_WIDTH-1:0]   M1_WR_DATA,
  input  logic [DATA_WIDTH/8-1:0] M1_WR_DATA_STRB,
  input  logic                    M1_WR_DATA_LAST,
  input  logic                    M1_WR_DATA_VALID,
  output logic                    M1_WR_DATA_READY,
  output logic [MID_WIDTH-1:0]    M1_WR_BACK_ID,
  output logic [1:0]              M1_WR_BACK_RESP,
  output logic                    M1_WR_BACK_VALID,
  input  logic                    M1_WR_BACK_READY,
  input  logic [MID_WIDTH-1:0]    M1_RD_ADDR_ID,
  input  logic [31:0]             M1_RD_ADDR,
  input  logic [7:0]              M1_RD_ADDR_LEN,
  input  logic [1:0]              M1_RD_ADDR_BURST,
  input  logic                    M1_RD_ADDR_VALID,
  output logic                    M1_RD_ADDR_READY,
  output logic [MID_WIDTH-1:0]    M1_RD_BACK_ID,
  output logic [DATA_WIDTH-1:0]   M1_RD_DATA,
  output logic [1:0]              M1_RD_DATA_RESP,
  output logic                    M1_RD_DATA_LAST,
  output logic                    M1_RD_DATA_VALID,
  input  logic                    M1_RD_DATA_READY,
  // DDR slave
  output logic [MID_WIDTH:0]      S_WR_ADDR_ID,
  output logic [31:0]             S_WR_ADDR,
  output logic [7:0]              S_WR_ADDR_LEN,
  output logic [1:0]              S_WR_ADDR_BURST,
  output logic                    S_WR_ADDR_VALID,
  input  logic                    S_WR_ADDR_READY,
  output logic [DATA_WIDTH-1:0]   S_WR_DATA,
  output logic [DATA_WIDTH/8-1:0] S_WR_DATA_STRB,
  output logic                    S_WR_DATA_LAST,
  output logic                    S_WR_DATA_VALID,
  input  logic                    S_WR_DATA_READY,
  input  logic [MID_WIDTH:0]      S_WR_BACK_ID,
  input  logic [1:0]              S_WR_BACK_RESP,
  input  logic                    S_WR_BACK_VALID,
  output logic                    S_WR_BACK_READY,
  output logic [MID_WIDTH:0]      S_RD_ADDR_ID,
  output logic [31:0]             S_RD_ADDR,
  output logic [7:0]              S_RD_ADDR_LEN,
  output logic [1:0]              S_RD_ADDR_BURST,
  output logic                    S_RD_ADDR_VALID,
  input  logic                    S_RD_ADDR_READY,
  input  logic [MID_WIDTH:0]      S_RD_BACK_ID,
  input  logic [DATA_WIDTH-1:0]   S_RD_BACK_DATA,
  input  logic [1:0]              S_RD_BACK_DATA_RESP,
  input  logic                    S_RD_BACK_DATA_LAST,
  input  logic                    S_RD_BACK_DATA_VALID,
  output logic                    S_RD_DATA_READY
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_t;
  typedef enum logic       {R_IDLE, R_ADDR}         r_state_t;

  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;
  logic     r_wgnt, r_wptr, w_wgnt_nxt, w_wptr_nxt;
  logic     r_rgnt, r_rptr, w_rgnt_nxt, w_rptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_wgnt   <= 1'b0;
      r_wptr   <= 1'b0;
      r_rgnt   <= 1'b0;
      r_rptr   <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      r_wgnt   <= w_wgnt_nxt;
      r_wptr   <= w_wptr_nxt;
      r_rgnt   <= w_rgnt_nxt;
      r_rptr   <= w_rptr_nxt;
    end
  end

  // Granted-master field muxes; qualified by the FSM through the VALIDs only.
  assign S_WR_ADDR_ID    = {r_wgnt, r_wgnt ? M1_WR_ADDR_ID : M0_WR_ADDR_ID};
  assign S_WR_ADDR       = r_wgnt ? M1_WR_ADDR       : M0_WR_ADDR;
  assign S_WR_ADDR_LEN   = r_wgnt ? M1_WR_ADDR_LEN   : M0_WR_ADDR_LEN;
  assign S_WR_ADDR_BURST = r_wgnt ? M1_WR_ADDR_BURST : M0_WR_ADDR_BURST;
  assign S_WR_DATA       = r_wgnt ? M1_WR_DATA       : M0_WR_DATA;
  assign S_WR_DATA_STRB  = r_wgnt ? M1_WR_DATA_STRB  : M0_WR_DATA_STRB;
  assign S_WR_DATA_LAST  = r_wgnt ? M1_WR_DATA_LAST  : M0_WR_DATA_LAST;
  assign S_RD_ADDR_ID    = {r_rgnt, r_rgnt ? M1_RD_ADDR_ID : M0_RD_ADDR_ID};
  assign S_RD_ADDR       = r_rgnt ? M1_RD_ADDR       : M0_RD_ADDR;
  assign S_RD_ADDR_LEN   = r_rgnt ? M1_RD_ADDR_LEN   : M0_RD_ADDR_LEN;
  assign S_RD_ADDR_BURST = r_rgnt ? M1_RD_ADDR_BURST : M0_RD_ADDR_BURST;

  // Write path: AW then the whole W burst from the same master.
  always_comb begin
    w_wstate_nxt     = r_wstate;
    w_wgnt_nxt       = r_wgnt;
    w_wptr_nxt       = r_wptr;
    S_WR_ADDR_VALID  = 1'b0;
    S_WR_DATA_VALID  = 1'b0;
    M0_WR_ADDR_READY = 1'b0;
    M1_WR_ADDR_READY = 1'b0;
    M0_WR_DATA_READY = 1'b0;
    M1_WR_DATA_READY = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        if (M0_WR_ADDR_VALID || M1_WR_ADDR_VALID) begin
          w_wgnt_nxt   = (M0_WR_ADDR_VALID && M1_WR_ADDR_VALID) ? r_wptr : M1_WR_ADDR_VALID;
          w_wstate_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        S_WR_ADDR_VALID  = r_wgnt ? M1_WR_ADDR_VALID : M0_WR_ADDR_VALID;
        M0_WR_ADDR_READY = !r_wgnt && S_WR_ADDR_READY;
        M1_WR_ADDR_READY =  r_wgnt && S_WR_ADDR_READY;
        if (S_WR_ADDR_VALID && S_WR_ADDR_READY) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        S_WR_DATA_VALID  = r_wgnt ? M1_WR_DATA_VALID : M0_WR_DATA_VALID;
        M0_WR_DATA_READY = !r_wgnt && S_WR_DATA_READY;
        M1_WR_DATA_READY =  r_wgnt && S_WR_DATA_READY;
        if (S_WR_DATA_VALID && S_WR_DATA_READY && S_WR_DATA_LAST) begin
          w_wptr_nxt   = !r_wgnt;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read path: only AR is arbitrated; reads may be outstanding.
  always_comb begin
    w_rstate_nxt     = r_rstate;
    w_rgnt_nxt       = r_rgnt;
    w_rptr_nxt       = r_rptr;
    S_RD_ADDR_VALID  = 1'b0;
    M0_RD_ADDR_READY = 1'b0;
    M1_RD_ADDR_READY = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        if (M0_RD_ADDR_VALID || M1_RD_ADDR_VALID) begin
          w_rgnt_nxt   = (M0_RD_ADDR_VALID && M1_RD_ADDR_VALID) ? r_rptr : M1_RD_ADDR_VALID;
          w_rstate_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        S_RD_ADDR_VALID  = r_rgnt ? M1_RD_ADDR_VALID : M0_RD_ADDR_VALID;
        M0_RD_ADDR_READY = !r_rgnt && S_RD_ADDR_READY;
        M1_RD_ADDR_READY =  r_rgnt && S_RD_ADDR_READY;
        if (S_RD_ADDR_VALID && S_RD_ADDR_READY) begin
          w_rptr_nxt   = !r_rgnt;
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Response routing by ID MSB.
  logic w_bsel, w_rsel;
  assign w_bsel = S_WR_BACK_ID[MID_WIDTH];
  assign w_rsel = S_RD_BACK_ID[MID_WIDTH];

  assign M0_WR_BACK_ID    = S_WR_BACK_ID[MID_WIDTH-1:0];
  assign M1_WR_BACK_ID    = S_WR_BACK_ID[MID_WIDTH-1:0];
  assign M0_WR_BACK_RESP  = S_WR_BACK_RESP;
  assign M1_WR_BACK_RESP  = S_WR_BACK_RESP;
  assign M0_WR_BACK_VALID = S_WR_BACK_VALID && !w_bsel;
  assign M1_WR_BACK_VALID = S_WR_BACK_VALID &&  w_bsel;
  assign S_WR_BACK_READY  = w_bsel ? M1_WR_BACK_READY : M0_WR_BACK_READY;

  assign M0_RD_BACK_ID    = S_RD_BACK_ID[MID_WIDTH-1:0];
  assign M1_RD_BACK_ID    = S_RD_BACK_ID[MID_WIDTH-1:0];
  assign M0_RD_DATA       = S_RD_BACK_DATA;
  assign M1_RD_DATA       = S_RD_BACK_DATA;
  assign M0_RD_DATA_RESP  = S_RD_BACK_DATA_RESP;
  assign M1_RD_DATA_RESP  = S_RD_BACK_DATA_RESP;
  assign M0_RD_DATA_LAST  = S_RD_BACK_DATA_LAST;
  assign M1_RD_DATA_LAST  = S_RD_BACK_DATA_LAST;
  assign M0_RD_DATA_VALID = S_RD_BACK_DATA_VALID && !w_rsel;
  assign M1_RD_DATA_VALID = S_RD_BACK_DATA_VALID &&  w_rsel;
  assign S_RD_DATA_READY  = w_rsel ? M1_RD_DATA_READY : M0_RD_DATA_READY;

endmodule

// File: tb/tb_ddr_slave_axi_arb2.sv
// Self-checking bench for ddr_slave_axi_arb2: table-driven B routing,
// randomized R routing against a simple model, randomized write arbitration
// against a last-served round-robin model, and directed multi-cycle sequences.
module tb_ddr_slave_axi_arb2;

  logic clk, rst;

  logic       aw_v[2];
  logic [2:0] aw_id[2];
  logic [31:0] aw_addr[2];
  logic [7:0] aw_len[2];
  logic [1:0] aw_burst[2];
  logic       wd_v[2];
  logic [31:0] wd_base[2];
  logic [7:0] wd_beat[2];
  logic       bready[2];
  logic       ar_v[2];
  logic [2:0] ar_id[2];
  logic [31:0] ar_addr[2];
  logic [7:0] ar_len[2];
  logic       rready[2];

  logic m_awr[2], m_wdr[2], m_arr[2];
  logic m_bv[2], m_rv[2];
  logic [2:0] m_bid[2], m_rid[2];
  logic [1:0] m_bresp[2], m_rresp[2];
  logic [31:0] m_rdata[2];
  logic m_rlast[2];

  logic [3:0]  S_WR_ADDR_ID, S_RD_ADDR_ID, S_WR_BACK_ID, S_RD_BACK_ID;
  logic [31:0] S_WR_ADDR, S_RD_ADDR, S_WR_DATA, S_RD_BACK_DATA;
  logic [7:0]  S_WR_ADDR_LEN, S_RD_ADDR_LEN;
  logic [1:0]  S_WR_ADDR_BURST, S_RD_ADDR_BURST, S_WR_BACK_RESP, S_RD_BACK_DATA_RESP;
  logic [3:0]  S_WR_DATA_STRB;
  logic S_WR_ADDR_VALID, S_WR_ADDR_READY, S_WR_DATA_LAST, S_WR_DATA_VALID, S_WR_DATA_READY;
  logic S_WR_BACK_VALID, S_WR_BACK_READY, S_RD_ADDR_VALID, S_RD_ADDR_READY;
  logic S_RD_BACK_DATA_LAST, S_RD_BACK_DATA_VALID, S_RD_DATA_READY;

  ddr_slave_axi_arb2 #(.MID_WIDTH(3), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .M0_WR_ADDR_ID(aw_id[0]), .M0_WR_ADDR(aw_addr[0]), .M0_WR_ADDR_LEN(aw_len[0]),
    .M0_WR_ADDR_BURST(aw_burst[0]), .M0_WR_ADDR_VALID(aw_v[0]), .M0_WR_ADDR_READY(m_awr[0]),
    .M0_WR_DATA(wd_base[0] + 32'(wd_beat[0])), .M0_WR_DATA_STRB(wd_base[0][3:0]),
    .M0_WR_DATA_LAST(wd_beat[0] == aw_len[0]), .M0_WR_DATA_VALID(wd_v[0]), .M0_WR_DATA_READY(m_wdr[0]),
    .M0_WR_BACK_ID(m_bid[0]), .M0_WR_BACK_RESP(m_bresp[0]), .M0_WR_BACK_VALID(m_bv[0]),
    .M0_WR_BACK_READY(bready[0]),
    .M0_RD_ADDR_ID(ar_id[0]), .M0_RD_ADDR(ar_addr[0]), .M0_RD_ADDR_LEN(ar_len[0]),
    .M0_RD_ADDR_BURST(2'b01), .M0_RD_ADDR_VALID(ar_v[0]), .M0_RD_ADDR_READY(m_arr[0]),
    .M0_RD_BACK_ID(m_rid[0]), .M0_RD_DATA(m_rdata[0]), .M0_RD_DATA_RESP(m_rresp[0]),
    .M0_RD_DATA_LAST(m_rlast[0]), .M0_RD_DATA_VALID(m_rv[0]), .M0_RD_DATA_READY(rready[0]),
    .M1_WR_ADDR_ID(aw_id[1]), .M1_WR_ADDR(aw_addr[1]), .M1_WR_ADDR_LEN(aw_len[1]),
    .M1_WR_ADDR_BURST(aw_burst[1]), .M1_WR_ADDR_VALID(aw_v[1]), .M1_WR_ADDR_READY(m_awr[1]),
    .M1_WR_DATA(wd_base[1] + 32'(wd_beat[1])), .M1_WR_DATA_STRB(wd_base[1][3:0]),
    .M1_WR_DATA_LAST(wd_beat[1] == aw_len[1]), .M1_WR_DATA_VALID(wd_v[1]), .M1_WR_DATA_READY(m_wdr[1]),
    .M1_WR_BACK_ID(m_bid[1]), .M1_WR_BACK_RESP(m_bresp[1]), .M1_WR_BACK_VALID(m_bv[1]),
    .M1_WR_BACK_READY(bready[1]),
    .M1_RD_ADDR_ID(ar_id[1]), .M1_RD_ADDR(ar_addr[1]), .M1_RD_ADDR_LEN(ar_len[1]),
    .M1_RD_ADDR_BURST(2'b01), .M1_RD_ADDR_VALID(ar_v[1]), .M1_RD_ADDR_READY(m_arr[1]),
    .M1_RD_BACK_ID(m_rid[1]), .M1_RD_DATA(m_rdata[1]), .M1_RD_DATA_RESP(m_rresp[1]),
    .M1_RD_DATA_LAST(m_rlast[1]), .M1_RD_DATA_VALID(m_rv[1]), .M1_RD_DATA_READY(rready[1]),
    .S_WR_ADDR_ID(S_WR_ADDR_ID), .S_WR_ADDR(S_WR_ADDR), .S_WR_ADDR_LEN(S_WR_ADDR_LEN),
    .S_WR_ADDR_BURST(S_WR_ADDR_BURST), .S_WR_ADDR_VALID(S_WR_ADDR_VALID), .S_WR_ADDR_READY(S_WR_ADDR_READY),
    .S_WR_DATA(S_WR_DATA), .S_WR_DATA_STRB(S_WR_DATA_STRB), .S_WR_DATA_LAST(S_WR_DATA_LAST),
    .S_WR_DATA_VALID(S_WR_DATA_VALID), .S_WR_DATA_READY(S_WR_DATA_READY),
    .S_WR_BACK_ID(S_WR_BACK_ID), .S_WR_BACK_RESP(S_WR_BACK_RESP), .S_WR_BACK_VALID(S_WR_BACK_VALID),
    .S_WR_BACK_READY(S_WR_BACK_READY),
    .S_RD_ADDR_ID(S_RD_ADDR_ID), .S_RD_ADDR(S_RD_ADDR), .S_RD_ADDR_LEN(S_RD_ADDR_LEN),
    .S_RD_ADDR_BURST(S_RD_ADDR_BURST), .S_RD_ADDR_VALID(S_RD_ADDR_VALID), .S_RD_ADDR_READY(S_RD_ADDR_READY),
    .S_RD_BACK_ID(S_RD_BACK_ID), .S_RD_BACK_DATA(S_RD_BACK_DATA), .S_RD_BACK_DATA_RESP(S_RD_BACK_DATA_RESP),
    .S_RD_BACK_DATA_LAST(S_RD_BACK_DATA_LAST), .S_RD_BACK_DATA_VALID(S_RD_BACK_DATA_VALID),
    .S_RD_DATA_READY(S_RD_DATA_READY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic pend[2];
  int last_w, last_r;   // master served most recently (model of round-robin)

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input int last, input logic p0, input logic p1);
    if (p0 && p1) return (last == 0) ? 1 : 0;
    return p1 ? 1 : 0;
  endfunction

  task automatic make_req(input int m);
    aw_v[m]     = 1'b1;
    aw_id[m]    = 3'($urandom);
    aw_addr[m]  = $urandom & 32'hFFFF_FFFC;
    aw_len[m]   = 8'($urandom_range(0, 3));
    aw_burst[m] = 2'($urandom);
    wd_base[m]  = $urandom;
    wd_beat[m]  = 8'd0;
    wd_v[m]     = 1'b1;
    pend[m]     = 1'b1;
  endtask

  task automatic aw_phase(input int w);
    int n;
    n = 0;
    #1;
    while (!S_WR_ADDR_VALID && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("aw_valid", S_WR_ADDR_VALID, 1);
    check("aw_id", S_WR_ADDR_ID, {1'(w), aw_id[w]});
    check("aw_addr", S_WR_ADDR, aw_addr[w]);
    check("aw_len", S_WR_ADDR_LEN, aw_len[w]);
    check("aw_burst", S_WR_ADDR_BURST, aw_burst[w]);
    check("aw_rdy_gnt", m_awr[w], 1);
    check("aw_rdy_other", m_awr[1-w], 0);
    @(posedge clk); #1;
    aw_v[w] = 1'b0;
    pend[w] = 1'b0;
  endtask

  task automatic data_phase(input int w, input int abort_at);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < 200) begin
      S_WR_DATA_READY = 1'($urandom_range(0, 1));
      #1;
      check("wd_valid", S_WR_DATA_VALID, 1);
      check("wd_data", S_WR_DATA, wd_base[w] + 32'(wd_beat[w]));
      check("wd_strb", S_WR_DATA_STRB, wd_base[w][3:0]);
      check("wd_last", S_WR_DATA_LAST, wd_beat[w] == aw_len[w]);
      check("wd_rdy_gnt", m_wdr[w], S_WR_DATA_READY);
      check("wd_rdy_other", m_wdr[1-w], 0);
      if (abort_at >= 0 && int'(wd_beat[w]) == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_aw_valid", S_WR_ADDR_VALID, 0);
        check("rst_wd_valid", S_WR_DATA_VALID, 0);
        check("rst_wd_rdy", m_wdr[w], 0);
        check("rst_ar_valid", S_RD_ADDR_VALID, 0);
        for (int m = 0; m < 2; m++) begin
          aw_v[m] = 1'b0; wd_v[m] = 1'b0; ar_v[m] = 1'b0; pend[m] = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_w = 1; last_r = 1;
        return;
      end
      @(posedge clk); #1;
      if (S_WR_DATA_READY) begin
        if (wd_beat[w] == aw_len[w]) begin
          wd_v[w] = 1'b0;
          done = 1;
        end else begin
          wd_beat[w] = wd_beat[w] + 8'd1;
        end
      end
      n++;
    end
    if (!done) check("wd_timeout", 0, 1);
  endtask

  task automatic serve();
    int w;
    w = pick(last_w, pend[0], pend[1]);
    aw_phase(w);
    data_phase(w, -1);
    last_w = w;
  endtask

  task automatic serve_read();
    int r, n;
    r = pick(last_r, ar_v[0], ar_v[1]);
    n = 0;
    #1;
    while (!S_RD_ADDR_VALID && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("ar_valid", S_RD_ADDR_VALID, 1);
    check("ar_id", S_RD_ADDR_ID, {1'(r), ar_id[r]});
    check("ar_addr", S_RD_ADDR, ar_addr[r]);
    check("ar_len", S_RD_ADDR_LEN, ar_len[r]);
    check("ar_rdy_gnt", m_arr[r], 1);
    check("ar_rdy_other", m_arr[1-r], 0);
    @(posedge clk); #1;
    ar_v[r] = 1'b0;
    last_r = r;
  endtask

  typedef struct {
    logic [3:0] sid; logic sv; logic r0; logic r1;
    logic e_v0; logic e_v1; logic [2:0] e_id; logic e_sr;
  } bvec_t;
  bvec_t bt[6];

  initial begin
    bt[0] = '{4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1};
    bt[1] = '{4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0};
    bt[2] = '{4'hD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0};
    bt[3] = '{4'hD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1};
    bt[4] = '{4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1};
    bt[5] = '{4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1};

    for (int m = 0; m < 2; m++) begin
      aw_v[m] = 0; aw_id[m] = 0; aw_addr[m] = 0; aw_len[m] = 0; aw_burst[m] = 0;
      wd_v[m] = 0; wd_base[m] = 0; wd_beat[m] = 0; bready[m] = 0;
      ar_v[m] = 0; ar_id[m] = 0; ar_addr[m] = 0; ar_len[m] = 0; rready[m] = 0;
      pend[m] = 0;
    end
    S_WR_ADDR_READY = 1; S_WR_DATA_READY = 1; S_RD_ADDR_READY = 1;
    S_WR_BACK_ID = 0; S_WR_BACK_RESP = 0; S_WR_BACK_VALID = 0;
    S_RD_BACK_ID = 0; S_RD_BACK_DATA = 0; S_RD_BACK_DATA_RESP = 0;
    S_RD_BACK_DATA_LAST = 0; S_RD_BACK_DATA_VALID = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_aw_v", S_WR_ADDR_VALID, 0);
    check("rst_s_w_v", S_WR_DATA_VALID, 0);
    check("rst_s_ar_v", S_RD_ADDR_VALID, 0);
    check("rst_m_rdy", {m_awr[0], m_awr[1], m_wdr[0], m_wdr[1], m_arr[0], m_arr[1]}, 0);
    check("rst_m_bv", {m_bv[0], m_bv[1], m_rv[0], m_rv[1]}, 0);
    rst = 0;
    last_w = 1; last_r = 1;

    // Ties after reset: M0, then M1, then M0 again.
    make_req(0); make_req(1);
    serve(); serve();
    make_req(0); make_req(1);
    serve(); serve();

    // M0 alone: addr 0x100, LEN 3, ID 5; AW reaches slave one cycle later.
    make_req(0);
    aw_id[0] = 3'd5; aw_addr[0] = 32'h100; aw_len[0] = 8'd3;
    #1;
    check("aw_not_early", S_WR_ADDR_VALID, 0);
    @(posedge clk); #1;
    check("aw_one_cycle", S_WR_ADDR_VALID, 1);
    check("aw_sid5", S_WR_ADDR_ID, 4'h5);
    aw_phase(0);
    data_phase(0, -1);
    last_w = 0;

    // B routing table.
    for (int i = 0; i < 6; i++) begin
      S_WR_BACK_ID = bt[i].sid; S_WR_BACK_VALID = bt[i].sv;
      S_WR_BACK_RESP = bt[i].sid[1:0];
      bready[0] = bt[i].r0; bready[1] = bt[i].r1;
      #1;
      check("b_v0", m_bv[0], bt[i].e_v0);
      check("b_v1", m_bv[1], bt[i].e_v1);
      check("b_id0", m_bid[0], bt[i].e_id);
      check("b_id1", m_bid[1], bt[i].e_id);
      check("b_resp", m_bresp[bt[i].sid[3]], bt[i].sid[1:0]);
      check("b_sready", S_WR_BACK_READY, bt[i].e_sr);
    end
    S_WR_BACK_VALID = 0;

    // Reads: both ID 2, back-to-back; slave answers M1 first.
    ar_v[0] = 1; ar_id[0] = 3'd2; ar_addr[0] = 32'h2000; ar_len[0] = 8'd1;
    ar_v[1] = 1; ar_id[1] = 3'd2; ar_addr[1] = 32'h3000; ar_len[1] = 8'd0;
    serve_read(); serve_read();
    S_RD_BACK_ID = 4'hA; S_RD_BACK_DATA = 32'hCAFE_0001; S_RD_BACK_DATA_RESP = 2'b01;
    S_RD_BACK_DATA_LAST = 1; S_RD_BACK_DATA_VALID = 1;
    rready[0] = 1; rready[1] = 0;
    #1;
    check("r_m1_v", m_rv[1], 1);
    check("r_m0_v", m_rv[0], 0);
    check("r_m1_id", m_rid[1], 3'd2);
    check("r_m1_data", m_rdata[1], 32'hCAFE_0001);
    check("r_m1_last", m_rlast[1], 1);
    check("r_stall", S_RD_DATA_READY, 0);
    rready[1] = 1;
    #1;
    check("r_release", S_RD_DATA_READY, 1);
    S_RD_BACK_DATA_VALID = 0;

    // Randomized R routing.
    for (int i = 0; i < 40; i++) begin
      S_RD_BACK_ID = 4'($urandom); S_RD_BACK_DATA = $urandom;
      S_RD_BACK_DATA_RESP = 2'($urandom); S_RD_BACK_DATA_LAST = 1'($urandom);
      S_RD_BACK_DATA_VALID = 1'($urandom); rready[0] = 1'($urandom); rready[1] = 1'($urandom);
      #1;
      check("rr_v0", m_rv[0], S_RD_BACK_DATA_VALID && (S_RD_BACK_ID < 8));
      check("rr_v1", m_rv[1], S_RD_BACK_DATA_VALID && (S_RD_BACK_ID >= 8));
      check("rr_id", m_rid[S_RD_BACK_ID >= 8], 3'(S_RD_BACK_ID % 8));
      check("rr_data", {m_rdata[S_RD_BACK_ID >= 8], m_rresp[S_RD_BACK_ID >= 8], m_rlast[S_RD_BACK_ID >= 8]},
            {S_RD_BACK_DATA, S_RD_BACK_DATA_RESP, S_RD_BACK_DATA_LAST});
      check("rr_sready", S_RD_DATA_READY, (S_RD_BACK_ID >= 8) ? rready[1] : rready[0]);
    end
    S_RD_BACK_DATA_VALID = 0;

    // Simultaneous write (M0) and read (M1).
    make_req(0);
    ar_v[1] = 1; ar_id[1] = 3'd3; ar_addr[1] = 32'h4440; ar_len[1] = 8'd7;
    @(posedge clk); #1;
    check("both_aw_v", S_WR_ADDR_VALID, 1);
    check("both_ar_v", S_RD_ADDR_VALID, 1);
    check("both_ar_id", S_RD_ADDR_ID, {1'b1, ar_id[1]});
    aw_phase(0);
    ar_v[1] = 0; last_r = 1;
    data_phase(0, -1);
    last_w = 0;

    // Randomized write arbitration against the round-robin model.
    for (int t = 0; t < 30; t++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 1) == 1) make_req(m);
      if (!pend[0] && !pend[1]) make_req(int'($urandom_range(0, 1)));
      serve();
    end
    while (pend[0] || pend[1]) serve();

    // Reset mid-burst: M0 served (pointer moves to M1), M1 aborted at beat 2.
    make_req(0);
    serve();
    make_req(1);
    aw_len[1] = 8'd3;
    aw_phase(1);
    data_phase(1, 2);
    // Pointer must be back at M0.
    make_req(0); make_req(1);
    serve(); serve();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_slave_axi_arb2.md
Name: ddr_slave_axi_arb2

Overview:
- Two-master arbiter that shares the single DDR slave AXI-style port (address/data/response channels, 32-bit data) between two requesters, e.g. the host bridge and the remote-lab capture engine.
- Read and write paths are arbitrated independently with round-robin priority.
- The master index is prepended to the outgoing ID, so responses route back by ID MSB without any tracking state.
- Sits between the requesters and the DDR3 slave wrapper, in the DDR slave clock domain.

Parameters:
MID_WIDTH, 3, master-side ID width; slave-side ID width is MID_WIDTH+1 (=4, matching the DDR slave port).
DATA_WIDTH, 32, data width; strobe width DATA_WIDTH/8.

Ports:
clk  in  1  DDR slave clock (DDR_SLAVE_CLK)
rst  in  1  synchronous active-high reset
Mx_WR_ADDR_ID/_ADDR/_LEN/_BURST/_VALID  in  3/32/8/2/1  master x (x=0,1) write address
Mx_WR_ADDR_READY  out  1
Mx_WR_DATA/_STRB/_LAST/_VALID  in  32/4/1/1  master x write data
Mx_WR_DATA_READY  out  1
Mx_WR_BACK_ID/_RESP/_VALID  out  3/2/1  master x write response
Mx_WR_BACK_READY  in  1
Mx_RD_ADDR_ID/_ADDR/_LEN/_BURST/_VALID  in  3/32/8/2/1  master x read address
Mx_RD_ADDR_READY  out  1
Mx_RD_BACK_ID/_DATA/_DATA_RESP/_DATA_LAST/_DATA_VALID  out  3/32/2/1/1  master x read data
Mx_RD_DATA_READY  in  1
S_WR_ADDR_ID/_ADDR/_LEN/_BURST/_VALID  out  4/32/8/2/1  to DDR slave
S_WR_ADDR_READY  in  1
S_WR_DATA/_STRB/_LAST/_VALID  out  32/4/1/1
S_WR_DATA_READY  in  1
S_WR_BACK_ID/_RESP/_VALID  in  4/2/1
S_WR_BACK_READY  out  1
S_RD_ADDR_ID/_ADDR/_LEN/_BURST/_VALID  out  4/32/8/2/1
S_RD_ADDR_READY  in  1
S_RD_BACK_ID/_DATA/_DATA_RESP/_DATA_LAST/_DATA_VALID  in  4/32/2/1/1
S_RD_DATA_READY  out  1

Behaviour:
- Reset: all VALID/READY outputs 0; write FSM W_IDLE; read FSM R_IDLE; both round-robin pointers = master 0 (master 0 wins first tie).
- Write FSM W_IDLE -> W_ADDR -> W_DATA -> W_IDLE:
  - W_IDLE: if any Mx_WR_ADDR_VALID, register the winner as wgnt and go to W_ADDR. Winner is the only requester, or the round-robin pointer on a tie. No slave VALID in W_IDLE.
  - W_ADDR: S_WR_ADDR_* = granted master's fields, S_WR_ADDR_ID = {wgnt, Mx_ID}; Mwgnt_WR_ADDR_READY = S_WR_ADDR_READY (combinational). On handshake go to W_DATA. Slave AW VALID therefore appears 1 cycle after master VALID.
  - W_DATA: W channel passes through from the granted master only; the other master's WR_DATA_READY = 0. On handshake with S_WR_DATA_LAST=1, flip the write pointer to !wgnt and return to W_IDLE.
  - W data presented by a master before its grant is held off (READY=0). No AW/W interleave across masters.
- Read FSM R_IDLE -> R_ADDR -> R_IDLE: same arbitration; on the AR handshake, flip the read pointer and return to R_IDLE. Multiple outstanding reads are allowed.
- Response routing (combinational, no state):
  - B: S_WR_BACK_ID[3] selects master; Mx_WR_BACK_ID = S_ID[2:0]; S_WR_BACK_READY = selected master's READY; the other master's VALID = 0.
  - R: identical routing, with DATA/RESP/LAST passed through.
- Non-granted master's ADDR_READY is always 0.
- Masters must hold VALID and fields stable until their handshake. The arbiter never drops a VALID once asserted to the slave.
- Synchronous reset mid-burst aborts: FSMs go idle and outputs drop next edge. The system resets the slave simultaneously.

Test Plan:
- M0 write addr 0x100, LEN=3, ID=5, alone -> S_WR_ADDR_VALID 1 cycle later, S_ID=4'h5; 4 beats pass; B with S_ID=5 appears on M0 only, ID=5.
- M0 and M1 both AW VALID same cycle after reset -> M0 granted first (S_ID=0xx); after its LAST, M1 granted (S_ID=1xx); next tie -> M0 (round-robin alternates).
- M1 W data valid before its AW grant while M0 bursts -> M1_WR_DATA_READY=0 until M1 in W_DATA; no beat interleave on S_WR_DATA.
- M0 read ID=2 and M1 read ID=2 back-to-back; slave returns the M1 data (S_ID=0xA) first -> routed to M1 with ID=2, M0 sees no VALID; LAST/backpressure honoured via M1_RD_DATA_READY=0 stalling S_RD_DATA_READY.
- Write and read simultaneously from different masters -> both slave channels active in the same cycle, independent grants.
- Assert rst during W_DATA beat 2 of 4 -> next cycle all slave VALIDs 0, FSMs idle, pointers reset to master 0.
